lsu_writeback: RTL
==================

Name: lsu_writeback

Overview:
Load/store and writeback stage directly upstream of the register file. It accepts one memory or ALU-result operation per transaction from execute and runs the data-memory request/grant/response handshake. It aligns and sign/zero-extends load data, then drives the register-file write port (rd0_addr, rd0_wr_en, rd0_data). It back-pressures execute while a memory transaction is outstanding.

Parameters:
RSP_TIMEOUT, 64, cycles allowed from the start of REQ to the response before an access fault is declared (minimum 2).

Ports:
clk  in  1  clock
clk_en  in  1  clock enable; low freezes all state, including the timeout counter
rst_n  in  1  asynchronous reset, active low
ex_valid  in  1  operation from execute is valid
ex_ready  out  1  stage can accept; equals (state==IDLE)
ex_is_load  in  1  operation is a load
ex_is_store  in  1  operation is a store
ex_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
ex_addr  in  32  effective byte address
ex_store_data  in  32  rs2 value (dataBus_u)
ex_rd_addr  in  5  destination register (regAddr_t)
ex_rd_wr  in  1  ALU op writes rd
ex_alu_result  in  32  ALU result (dataBus_u)
dmem_req  out  1  memory request
dmem_we  out  1  1 = store
dmem_be  out  4  byte enables
dmem_addr  out  32  word-aligned address ({ex_addr[31:2],2'b00})
dmem_wdata  out  32  store data, replicated to lanes
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  response valid (loads and stores)
dmem_rdata  in  32  read data
dmem_err  in  1  bus error, qualified by dmem_rvalid
rd0_addr  out  5  register-file write address
rd0_wr_en  out  1  register-file write enable, one-cycle pulse
rd0_data  out  32  register-file write data
misalign_exc  out  1  one-cycle pulse: misaligned access
access_fault  out  1  one-cycle pulse: bus error, timeout or unsupported funct3
exc_addr  out  32  ex_addr of the faulting operation; held until the next fault

Behaviour:
- Reset:
  - state=IDLE; every output 0 except ex_ready=1; timeout counter 0.
  - Asserting reset mid-transaction drops dmem_req immediately and discards the transaction with no writeback and no exception.
- Accept condition: every action below requires clk_en=1 at the clock edge.
- IDLE, ex_valid, neither load nor store:
  - if ex_rd_wr and ex_rd_addr!=0, the next cycle gives rd0_wr_en=1, rd0_addr=ex_rd_addr, rd0_data=ex_alu_result (1-cycle latency).
- IDLE, ex_valid, load or store, alignment check first:
  - H/HU with addr[0]!=0, or W with addr[1:0]!=0 -> misalign_exc pulse next cycle; exc_addr latched; no request; stay IDLE.
  - Load funct3 011/110/111, or store funct3 >=011 -> access_fault pulse next cycle; no request.
- IDLE, valid aligned access:
  - Latch the operation and go to REQ.
  - dmem_req rises the next cycle; dmem_addr/be/we/wdata are registered and held stable until gnt.
- Store lanes (off = addr[1:0]):
  - SB: be = 0001<<off; wdata = byte replicated x4.
  - SH: be = 0011<<off; wdata = half replicated x2.
  - SW: be = 1111.
- Load byte enables: 1111 for all sizes.
- REQ: on dmem_gnt, dmem_req falls the following cycle; go to WAIT.
- WAIT: on dmem_rvalid:
  - dmem_err=1 -> access_fault pulse, no write.
  - otherwise, for a load: shift rdata right by 8*off, then sign- or zero-extend per funct3.
  - write occurs the cycle after rvalid, only if rd!=0.
  - return to IDLE in both cases.
- Load to x0: the bus access still happens; rd0_wr_en stays 0.
- Timeout: the counter runs in REQ and WAIT. On reaching RSP_TIMEOUT -> access_fault pulse, dmem_req=0, IDLE.
- Simultaneous gnt and rvalid in the REQ cycle: treated as gnt followed immediately by the response. The transaction completes as if in WAIT, with no extra cycle.
- ex_ready=0 in REQ and WAIT. Execute holds its inputs stable; while not ready, ex_valid is ignored.
- rd0_wr_en and the exception pulses are mutually exclusive; at most one fires per cycle.

Decomposition:
- riscv_definitions package gains:
  - mem_size_e (LB, LH, LW, LBU, LHU encodings)
  - lsu_state_e (IDLE, REQ, WAIT)
  - byteEn_t (logic [3:0])
- Reuse dataBus_u and regAddr_t from the same package.
- Sub-module lsu_load_align: combinational rdata + offset + funct3 -> extended dataBus_u. It is verified standalone.

Test Plan:
- LW, addr 0x100, rdata 0xDEADBEEF, gnt in the first REQ cycle, rvalid 2 cycles later -> rd0_wr_en pulse, rd0_data=0xDEADBEEF, rd0_addr=5.
- LB addr 0x103 and LBU addr 0x103, rdata 0x80FF_1234 -> 0xFFFFFF80 and 0x00000080. LH addr 0x102 -> 0xFFFF80FF.
- SB addr 0x201, data 0x000000AB -> dmem_be=0010, dmem_wdata=0xABABABAB, dmem_we=1, no rd0 write.
- LW addr 0x102 -> misalign_exc pulse, exc_addr=0x102, dmem_req never rises, ex_ready stays 1.
- Load with no gnt for RSP_TIMEOUT=64 cycles -> access_fault at cycle 64, then IDLE. A separate rvalid with err=1 -> access_fault, no write.
- ALU op to rd=0 -> no write. Reset during WAIT -> dmem_req=0 asynchronously, no writeback after release.

Source files
------------

// File: rtl/riscv_definitions_pkg.sv
// Shared RISC-V datapath types for the load/store and writeback stage.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package riscv_definitions;

    typedef logic [4:0] regAddr_t;
    typedef logic [3:0] byteEn_t;

    typedef union packed {
        logic [31:0]       word;
        logic [1:0][15:0]  half;
        logic [3:0][7:0]   bytes;
    } dataBus_u;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_e;

    // Halfword accesses need an even address, word accesses a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        logic [1:0] sz;
        sz = funct3[1:0];
        return ((sz == 2'b01) && off[0]) || ((sz == 2'b10) && (off != 2'b00));
    endfunction

    // Loads allow B/H/W/BU/HU; stores only B/H/W.
    function automatic logic is_unsupported(input logic is_load, input logic [2:0] funct3);
        if (is_load)
            return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        return funct3 >= 3'b011;
    endfunction

endpackage

// File: rtl/lsu_writeback_load_align.sv
// Aligns a read word to the addressed byte lane and sign/zero-extends it.
// Latency: combinational.
// Backpressure: none.
module lsu_load_align
    import riscv_definitions::*;
(
    input  dataBus_u    rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output dataBus_u    data
);

    logic [31:0] shifted;

    // Shift the addressed byte down to lane 0, then extend to the access size.
    always_comb begin
        shifted   = rdata.word >> {off, 3'b000};
        data.word = shifted;
        case (funct3)
            3'b000:  data.word = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  data.word = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  data.word = {24'h0, shifted[7:0]};
            3'b101:  data.word = {16'h0, shifted[15:0]};
            default: data.word = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_writeback.sv
// Load/store + writeback stage: runs the dmem req/gnt/rvalid handshake and drives the regfile write port.
// Latency: ALU writeback 1 cycle; memory ops 1 cycle to request, write/exception 1 cycle after rvalid.
// Backpressure: ex_ready low while a memory transaction is in REQ or WAIT; clk_en low freezes everything.
module lsu_writeback
    import riscv_definitions::*;
#(
    parameter int RSP_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        clk_en,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_is_load,
    input  logic        ex_is_store,
    input  logic [2:0]  ex_funct3,
    input  logic [31:0] ex_addr,
    input  dataBus_u    ex_store_data,
    input  regAddr_t    ex_rd_addr,
    input  logic        ex_rd_wr,
    input  dataBus_u    ex_alu_result,
    output logic        dmem_req,
    output logic        dmem_we,
    output byteEn_t     dmem_be,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_err,
    output regAddr_t    rd0_addr,
    output logic        rd0_wr_en,
    output dataBus_u    rd0_data,
    output logic        misalign_exc,
    output logic        access_fault,
    output logic [31:0] exc_addr
);

    localparam int CW = $clog2(RSP_TIMEOUT);

    lsu_state_e  state, state_nxt;
    logic [CW-1:0] cnt;

    // Operation captured at accept time, used when the response returns.
    logic        op_load;
    logic [2:0]  op_f3;
    logic [1:0]  op_off;
    regAddr_t    op_rd;
    logic [31:0] op_addr;

    logic        start, done, timeout;
    logic        wb_fire, mis_fire, flt_fire;
    regAddr_t    wb_addr;
    logic [31:0] wb_data, flt_addr;
    byteEn_t     st_be;
    logic [31:0] st_wdata;
    dataBus_u    load_data;

    lsu_load_align u_align (
        .rdata  (dataBus_u'(dmem_rdata)),
        .off    (op_off),
        .funct3 (op_f3),
        .data   (load_data)
    );

    assign ex_ready = (state == IDLE);
    assign dmem_req = (state == REQ);
    assign done     = dmem_rvalid && ((state == WAIT) || ((state == REQ) && dmem_gnt));
    assign timeout  = (state != IDLE) && !done && (cnt == CW'(RSP_TIMEOUT - 1));

    // Store lane steering: replicate the datum across lanes, enable only the addressed bytes.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = 32'h0;
        if (ex_is_store) begin
            case (ex_funct3[1:0])
                2'b00: begin
                    st_be    = 4'b0001 << ex_addr[1:0];
                    st_wdata = {4{ex_store_data.bytes[0]}};
                end
                2'b01: begin
                    st_be    = 4'b0011 << ex_addr[1:0];
                    st_wdata = {2{ex_store_data.half[0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = ex_store_data.word;
                end
            endcase
        end
    end

    // Next-state and single-cycle event decode; at most one of wb/mis/flt per cycle.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        wb_fire   = 1'b0;
        mis_fire  = 1'b0;
        flt_fire  = 1'b0;
        wb_addr   = op_rd;
        wb_data   = load_data.word;
        flt_addr  = op_addr;
        case (state)
            IDLE: begin
                if (ex_valid) begin
                    if (!ex_is_load && !ex_is_store) begin
                        wb_fire = ex_rd_wr && (ex_rd_addr != 5'd0);
                        wb_addr = ex_rd_addr;
                        wb_data = ex_alu_result.word;
                    end else if (is_misaligned(ex_funct3, ex_addr[1:0])) begin
                        mis_fire = 1'b1;
                        flt_addr = ex_addr;
                    end else if (is_unsupported(ex_is_load, ex_funct3)) begin
                        flt_fire = 1'b1;
                        flt_addr = ex_addr;
                    end else begin
                        start     = 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            REQ, WAIT: begin
                if (done) begin
                    state_nxt = IDLE;
                    flt_fire  = dmem_err;
                    wb_fire   = !dmem_err && op_load && (op_rd != 5'd0);
                end else if (state == REQ && dmem_gnt) begin
                    state_nxt = WAIT;
                end else if (timeout) begin
                    state_nxt = IDLE;
                    flt_fire  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else if (clk_en)
            state <= state_nxt;
    end

    // Response timeout counter, live only while a transaction is outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clk_en)
            cnt <= (state_nxt == IDLE || start) ? '0 : cnt + 1'b1;
    end

    // Capture the operation and the registered bus request on accept; held stable until gnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_load    <= 1'b0;
            op_f3      <= 3'b0;
            op_off     <= 2'b0;
            op_rd      <= 5'd0;
            op_addr    <= 32'h0;
            dmem_we    <= 1'b0;
            dmem_be    <= 4'b0;
            dmem_addr  <= 32'h0;
            dmem_wdata <= 32'h0;
        end else if (clk_en && start) begin
            op_load    <= ex_is_load;
            op_f3      <= ex_funct3;
            op_off     <= ex_addr[1:0];
            op_rd      <= ex_rd_addr;
            op_addr    <= ex_addr;
            dmem_we    <= !ex_is_load;
            dmem_be    <= st_be;
            dmem_addr  <= {ex_addr[31:2], 2'b00};
            dmem_wdata <= st_wdata;
        end
    end

    // Registered writeback port and exception pulses; exc_addr holds until the next fault.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd0_wr_en    <= 1'b0;
            rd0_addr     <= 5'd0;
            rd0_data     <= '0;
            misalign_exc <= 1'b0;
            access_fault <= 1'b0;
            exc_addr     <= 32'h0;
        end else if (clk_en) begin
            rd0_wr_en    <= wb_fire;
            misalign_exc <= mis_fire;
            access_fault <= flt_fire;
            if (wb_fire) begin
                rd0_addr      <= wb_addr;
                rd0_data.word <= wb_data;
            end
            if (mis_fire || flt_fire)
                exc_addr <= flt_addr;
        end
    end

endmodule
